// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the LEGv8 fetch stage: PS function codes, fetch FSM
// state constants, default reset PC and the branch-target helper.
package fetch_pkg;

    // PC function (PS) encodings; for 1x the source is chosen by PCsel
    localparam logic [1:0] PS_HOLD    = 2'b00;
    localparam logic [1:0] PS_INC     = 2'b01;
    localparam logic [1:0] PS_LOAD_A  = 2'b10;
    localparam logic [1:0] PS_LOAD_BR = 2'b11;

    // Fetch FSM states
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    // Word-offset relative target, 64-bit wrap-around
    function automatic logic [63:0] branch_target(input logic [63:0] base,
                                                  input logic [63:0] offset);
        return base + {offset[61:0], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: hold, PC+4, register target or
// pc_inst-relative branch target.
// Optional feature macro: PC_ALIGN_CHECK_EN (flags and clears misaligned
// load targets).
module pc_next_sel
    import fetch_pkg::*;
(
    input  logic [1:0]  PS,
    input  logic        PCsel,
    input  logic [63:0] PC,
    input  logic [63:0] pc_inst_base,
    input  logic [63:0] constant,
    input  logic [63:0] A,
`ifdef PC_ALIGN_CHECK_EN
    output logic        misaligned,
`endif
    output logic [63:0] next_pc
);

    logic [63:0] target;

    // Select load target and apply the PS function
    always_comb begin
        target  = PCsel ? branch_target(pc_inst_base, constant) : A;
`ifdef PC_ALIGN_CHECK_EN
        misaligned = |target[1:0];
`endif
        case (PS)
            PS_HOLD: next_pc = PC;
            PS_INC:  next_pc = PC + 64'd4;
            default: begin
`ifdef PC_ALIGN_CHECK_EN
                next_pc = {target[63:2], 2'b00};
`else
                next_pc = target;
`endif
            end
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// LEGv8 program-counter and instruction-fetch stage. Runs a req/ack fetch
// to instruction memory, latches I and pc_inst, applies PS/PCsel to PC and
// stalls the control unit while a fetch is outstanding.
// Optional feature macro: PC_ALIGN_CHECK_EN (adds sticky align_fault).
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned INST_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              IL,
    input  logic [1:0]        PS,
    input  logic              PCsel,
    input  logic [63:0]       constant,
    input  logic [63:0]       A,
    output logic [63:0]       imem_addr,
    output logic              imem_req,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic [INST_W-1:0] I,
    output logic [63:0]       PC,
    output logic [63:0]       pc_inst,
    output logic [63:0]       PC4,
`ifdef PC_ALIGN_CHECK_EN
    output logic              align_fault,
`endif
    output logic              stall
);

    logic [0:0]  state;
    logic [1:0]  ps_q;
    logic        pcsel_q;
    logic        fetch_done;
    logic [1:0]  ps_eff;
    logic        pcsel_eff;
    logic [63:0] base_eff;
    logic [63:0] next_pc;
`ifdef PC_ALIGN_CHECK_EN
    logic        misaligned;
    logic        pc_load;
`endif

    // In FETCH the deferred PS action is applied with PC as the new pc_inst
    // base, since pc_inst takes PC on the same edge.
    always_comb begin
        fetch_done = (state == FETCH) && imem_ack;
        ps_eff     = (state == FETCH) ? ps_q    : PS;
        pcsel_eff  = (state == FETCH) ? pcsel_q : PCsel;
        base_eff   = (state == FETCH) ? PC      : pc_inst;
        stall      = IL && !fetch_done;
        imem_req   = (state == FETCH);
        imem_addr  = PC;
        PC4        = pc_inst + 64'd4;
    end

    pc_next_sel u_next (
        .PS           (ps_eff),
        .PCsel        (pcsel_eff),
        .PC           (PC),
        .pc_inst_base (base_eff),
        .constant     (constant),
        .A            (A),
`ifdef PC_ALIGN_CHECK_EN
        .misaligned   (misaligned),
`endif
        .next_pc      (next_pc)
    );

    // Fetch FSM, PC, pc_inst and instruction register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            PC      <= RESET_PC;
            pc_inst <= RESET_PC;
            I       <= '0;
            ps_q    <= PS_HOLD;
            pcsel_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IL) begin
                        state   <= FETCH;
                        ps_q    <= PS;
                        pcsel_q <= PCsel;
                    end else begin
                        PC <= next_pc;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        I       <= imem_rdata;
                        pc_inst <= PC;
                        PC      <= next_pc;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    assign pc_load = ((state == IDLE) && !IL || fetch_done) && ps_eff[1];

    // Sticky misaligned-load flag, cleared only by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            align_fault <= 1'b0;
        else if (pc_load && misaligned)
            align_fault <= 1'b1;
    end
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage that feeds the LEGv8 multi-cycle control unit.
- Holds PC, runs a variable-latency req/ack handshake to instruction memory, and latches the instruction register I that the control unit decodes.
- Applies PS/PCsel from the control word to update PC.
- Raises stall to freeze the control unit's state register while a fetch is outstanding.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- INST_W, 32, instruction width; I resets to 0.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- IL  in  1  instruction-load request from the control word.
- PS  in  2  PC function: 00 hold, 01 PC+4, 10/11 load new PC.
- PCsel  in  1  new-PC source when PS[1]=1: 0 = A, 1 = branch target.
- constant  in  64  sign-extended word offset from the control unit's constant generator.
- A  in  64  register-file A bus (BR/BLR/RET target).
- imem_addr  out  64  fetch address.
- imem_req  out  1  fetch request.
- imem_rdata  in  32  fetched instruction.
- imem_ack  in  1  data valid and request complete.
- I  out  32  instruction register.
- PC  out  64  next fetch address.
- pc_inst  out  64  address of the instruction currently in I.
- PC4  out  64  pc_inst+4, the link value for BL.
- stall  out  1  hold the control-unit state register and datapath writes.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC, pc_inst=RESET_PC, I=0.
  - FSM=IDLE, imem_req=0.
  - Any pending fetch is abandoned.
- FSM state IDLE:
  - imem_req=0.
  - IL=1 → FETCH at the next edge; the PS/PCsel action is deferred.
  - IL=0 → the PS action is applied at this edge.
- FSM state FETCH:
  - imem_req=1, imem_addr=PC (registered path, stable for the whole handshake).
  - On a cycle with imem_ack=1, at that edge: I<=imem_rdata; pc_inst<=PC; apply the deferred PS action using the new pc_inst base; go to IDLE.
- stall = IL & ~(FSM==FETCH & imem_ack). This is a combinational ack→stall path.
  - Minimum IF cost is 2 cycles (IL cycle, then FETCH cycle with same-cycle ack).
  - Each extra wait cycle adds one.
- Control inputs are stable while stalled, because the control state is frozen. The PS latched at FETCH entry is used; later changes are ignored.
- Next-PC rules, 64-bit wrap-around with no overflow flag:
  - 00: PC unchanged.
  - 01: PC+4.
  - 1x, PCsel=1: pc_inst + (constant<<2), computed with the pc_inst value after any concurrent update.
  - 1x, PCsel=0: A.
- Relative branches use pc_inst, not PC, so B/CBZ/B.cond targets are relative to the branch instruction itself.
- PC4 is combinational from pc_inst.
- imem_ack while IDLE is ignored: no state change, and I/PC are unchanged.
- IL=0 while in FETCH cannot legally occur. If it does, the fetch still completes on ack and stall=0.
- Reset asserted mid-FETCH drops imem_req asynchronously. An ack after reset release is ignored.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output align_fault (1 bit, reset 0).
  - Any PC load (PS=1x) with target[1:0]≠0 sets align_fault sticky until reset.
  - The loaded PC has bits [1:0] forced to 00.
- Undefined:
  - No align_fault port.
  - Target is loaded unmodified.

Decomposition:
- Package fetch_pkg holds:
  - PS encodings PS_HOLD, PS_INC, PS_LOAD_A, PS_LOAD_BR.
  - FSM state constants IDLE/FETCH.
  - Default RESET_PC.
- Sub-module pc_next_sel: combinational next-PC mux and adders.
  - Inputs: PS, PCsel, PC, pc_inst_base, constant, A.
  - Outputs: next_pc and, under the macro, misaligned.
  - Instantiated once.

Test Plan:
- Zero-wait fetch: reset release, RESET_PC=0; IL=1, PS=01; ack in the first FETCH cycle with rdata=32'h8B020020.
  - stall high 1 cycle then low at ack.
  - I=8B020020, pc_inst=0, PC=4.
- Wait states: same as above but ack after 3 FETCH cycles.
  - stall=1 for 4 cycles.
  - imem_addr constant=4 throughout.
  - PC advances only once, to 8.
- Relative branch: pc_inst=0x100, PS=11, PCsel=1, constant=-2.
  - PC=0xF8.
  - constant=0x3FFFFFF sign-extended (-1): PC=0xFC.
- Register branch: PS=10, PCsel=0, A=0x4000 → PC=0x4000.
  - PS=00 → PC held.
  - PC4 = pc_inst+4 throughout.
- Reset mid-fetch: assert reset during FETCH.
  - imem_req drops immediately; PC=RESET_PC, I=0.
  - Stray ack next cycle causes no change.
- With PC_ALIGN_CHECK_EN: PS=10, A=0x4002.
  - PC=0x4000, align_fault=1, and it stays set after later aligned loads.
